rsv_issue_sched: RTL and testbench
==================================

Name: rsv_issue_sched

Overview:
- Issue scheduler for a 4-entry reservation station in the out-of-order core.
- Tracks the source-operand readiness of each occupied slot by snooping the common data bus (CDB) writeback tag.
- Each cycle it selects the oldest slot whose operands are both ready, and presents it to the station's execution unit through a registered valid/ready handshake.
- Slot payload storage stays in the station; this block owns only occupancy, readiness, age and issue sequencing.

Parameters:
- ENTRIES, 4, number of station slots (power of two, 2..8).
- IDX_W, 2, slot index width, equal to log2(ENTRIES).
- TAG_W, 5, ROB tag width used for operand wakeup.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; drops every slot and any pending issue.
- alloc_valid  in  1  decoder presents an instruction for the station.
- alloc_ready  out  1  a free slot exists; allocation fires when alloc_valid && alloc_ready.
- alloc_idx  out  IDX_W  slot the station must write the payload into (lowest free index).
- alloc_s1_tag  in  TAG_W  ROB tag of source 1.
- alloc_s1_rdy  in  1  source 1 value is already available.
- alloc_s2_tag  in  TAG_W  ROB tag of source 2.
- alloc_s2_rdy  in  1  source 2 value is already available.
- wb_valid  in  1  CDB broadcast valid.
- wb_tag  in  TAG_W  CDB broadcast ROB tag.
- issue_valid  out  1  registered; issue_idx holds a ready instruction.
- issue_idx  out  IDX_W  registered; slot being issued.
- issue_ready  in  1  execution unit accepts; issue fires when issue_valid && issue_ready.
- count  out  IDX_W+1  number of occupied slots.

Behaviour:
- Per-slot state: occ, s1_rdy, s2_rdy, s1_tag, s2_tag, inflight (slot is latched in the issue register), plus an ENTRIES x ENTRIES age matrix (older[i][j]=1 means i was allocated before j).
- Reset (rst=1 at an edge):
  - All occ/inflight/ready bits cleared; age matrix cleared.
  - issue_valid=0, issue_idx=0, count=0.
  - alloc_ready is forced to 0 while rst is high.
  - alloc_idx=0 whenever no slot is free.
- Allocation:
  - alloc_ready = !rst && !flush && count!=ENTRIES. It is computed from registered state only; a slot freed by an issue fire becomes allocatable the next cycle.
  - On fire, slot alloc_idx sets occ=1. Its row in the age matrix is cleared; its column is set for every other occupied slot.
- Wakeup:
  - While wb_valid=1, every occupied slot with s1_tag==wb_tag sets s1_rdy at the edge; the same applies to s2.
  - Bypass: an allocating source whose tag equals wb_tag while wb_valid=1 is stored as ready, regardless of alloc_sN_rdy.
  - A source already ready is unaffected by a matching tag.
- Selection (combinational):
  - cand[i] = occ && s1_rdy && s2_rdy && !inflight.
  - The selected slot is the cand slot older than all other cand slots. At most one is selected.
- Issue register, two states:
  - EMPTY (issue_valid=0): if any cand exists, load issue_idx, set that slot's inflight, go to HOLD.
  - HOLD (issue_valid=1): issue_idx stable while issue_ready=0.
  - On fire: clear occ/inflight of issue_idx, and in the same edge load the next cand (stay HOLD) or go to EMPTY. The slot just fired is never reloaded.
- Latencies (no older competitor):
  - Allocation with both sources ready at edge N gives issue_valid=1 after edge N+1.
  - wb_valid at edge N makes the dependent slot issue_valid after edge N+1.
- count:
  - +1 on alloc fire, -1 on issue fire; unchanged when both fire in the same cycle.
  - Never exceeds ENTRIES; never underflows.
- Flush:
  - Highest priority over alloc, wakeup and issue.
  - Next cycle: all slots empty, issue_valid=0, count=0.
  - An issue_ready coincident with flush is ignored (no fire is counted).
- rst mid-operation: identical to flush and also clears issue_idx.

Test Plan:
- Reset then alloc one instruction with s1_rdy=s2_rdy=1 at cycle 1 -> alloc_idx=0; issue_valid=1, issue_idx=0 at cycle 3; issue_ready=1 -> count returns 0 next cycle.
- Fill 4 slots (alloc_ready drops to 0 after the 4th). Slot 0 has s1_tag=7 not ready; slots 1-3 are ready -> issues in order 1,2,3. After wb_tag=7, slot 0 issues last; count reaches 0.
- Same-cycle bypass: alloc with s2_tag=12, s2_rdy=0, while wb_valid=1 and wb_tag=12 -> issue_valid two cycles later.
- Backpressure: issue_ready held 0 for 5 cycles with 2 ready slots -> issue_idx stable and the second slot not issued. Release -> back-to-back issues on consecutive cycles.
- Full with simultaneous fire: count=4, issue fire and alloc_valid in the same cycle -> alloc_ready stays 0 that cycle; count=3, then alloc accepted into the freed index next cycle.
- Flush with issue_valid=1 and issue_ready=1 in the same cycle -> next cycle issue_valid=0, count=0, alloc_ready=1. No slot is reported issued.

Source files
------------

// File: rtl/rsv_issue_sched_if.sv
// Handshake bundle between the reservation-station issue scheduler and its neighbours:
// the decoder allocation channel, the CDB snoop, the execution-unit issue channel and the occupancy count.
interface rsv_issue_sched_if #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 5
);
  logic             flush;

  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [TAG_W-1:0] alloc_s1_tag;
  logic             alloc_s1_rdy;
  logic [TAG_W-1:0] alloc_s2_tag;
  logic             alloc_s2_rdy;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;

  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_ready;

  logic [IDX_W:0]   count;

  modport master (
    output flush,
    output alloc_valid, alloc_s1_tag, alloc_s1_rdy, alloc_s2_tag, alloc_s2_rdy,
    output wb_valid, wb_tag,
    output issue_ready,
    input  alloc_ready, alloc_idx,
    input  issue_valid, issue_idx,
    input  count
  );

  modport slave (
    input  flush,
    input  alloc_valid, alloc_s1_tag, alloc_s1_rdy, alloc_s2_tag, alloc_s2_rdy,
    input  wb_valid, wb_tag,
    input  issue_ready,
    output alloc_ready, alloc_idx,
    output issue_valid, issue_idx,
    output count
  );
endinterface

// File: rtl/rsv_issue_sched.sv
// Issue scheduler for a small reservation station: tracks slot occupancy, operand readiness
// via CDB snooping and allocation age, and issues the oldest ready slot through a registered handshake.
module rsv_issue_sched #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2,
  parameter int TAG_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rsv_issue_sched_if.slave     bus
);

  typedef enum logic {
    ST_EMPTY,
    ST_HOLD
  } issue_state_t;

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  issue_state_t       state_q;
  issue_state_t       state_nxt;

  logic [ENTRIES-1:0] occ_q;
  logic [ENTRIES-1:0] s1_rdy_q;
  logic [ENTRIES-1:0] s2_rdy_q;
  logic [ENTRIES-1:0] inflight_q;
  logic [TAG_W-1:0]   s1_tag_q [ENTRIES];
  logic [TAG_W-1:0]   s2_tag_q [ENTRIES];
  logic [ENTRIES-1:0] older_q  [ENTRIES];
  logic [IDX_W-1:0]   issue_idx_q;
  logic [IDX_W:0]     count_q;

  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] sel_vec;
  logic               any_cand;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc_ready;
  logic               alloc_fire;
  logic               issue_fire;
  logic               load_issue;
  logic               s1_bypass;
  logic               s2_bypass;

  assign cand     = occ_q & s1_rdy_q & s2_rdy_q & ~inflight_q;
  assign any_cand = |cand;

  // A candidate wins only if it is older than every other candidate; the age matrix makes this one-hot.
  always_comb begin
    sel_vec = '0;
    sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sel_vec[i] = cand[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && cand[j] && !older_q[i][j]) begin
          sel_vec[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel_vec[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_ready = !rst && !bus.flush && (count_q != CNT_FULL);
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign issue_fire  = (state_q == ST_HOLD) && bus.issue_ready && !bus.flush && !rst;
  assign s1_bypass   = bus.wb_valid && (bus.wb_tag == bus.alloc_s1_tag);
  assign s2_bypass   = bus.wb_valid && (bus.wb_tag == bus.alloc_s2_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // The slot that fires is still marked inflight this cycle, so a same-edge reload never picks it again.
  always_comb begin
    state_nxt  = state_q;
    load_issue = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (any_cand) begin
          load_issue = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (issue_fire) begin
          if (any_cand) begin
            load_issue = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
    if (bus.flush) begin
      state_nxt  = ST_EMPTY;
      load_issue = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      s1_rdy_q    <= '0;
      s2_rdy_q    <= '0;
      inflight_q  <= '0;
      issue_idx_q <= '0;
      count_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        older_q[i]  <= '0;
      end
    end else if (bus.flush) begin
      occ_q      <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
    end else begin
      unique case ({alloc_fire, issue_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.wb_valid && occ_q[i] && (s1_tag_q[i] == bus.wb_tag)) begin
          s1_rdy_q[i] <= 1'b1;
        end
        if (bus.wb_valid && occ_q[i] && (s2_tag_q[i] == bus.wb_tag)) begin
          s2_rdy_q[i] <= 1'b1;
        end
      end

      if (issue_fire) begin
        occ_q[issue_idx_q]      <= 1'b0;
        inflight_q[issue_idx_q] <= 1'b0;
      end

      if (load_issue) begin
        issue_idx_q         <= sel_idx;
        inflight_q[sel_idx] <= 1'b1;
      end

      // New entry is the youngest: it is older than nobody, and every occupied slot is older than it.
      if (alloc_fire) begin
        occ_q[free_idx]    <= 1'b1;
        s1_tag_q[free_idx] <= bus.alloc_s1_tag;
        s2_tag_q[free_idx] <= bus.alloc_s2_tag;
        s1_rdy_q[free_idx] <= bus.alloc_s1_rdy || s1_bypass;
        s2_rdy_q[free_idx] <= bus.alloc_s2_rdy || s2_bypass;
        older_q[free_idx]  <= '0;
        for (int j = 0; j < ENTRIES; j++) begin
          if (occ_q[j] && (IDX_W'(j) != free_idx)) begin
            older_q[j][free_idx] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_idx   = free_idx;
  assign bus.issue_valid = (state_q == ST_HOLD);
  assign bus.issue_idx   = issue_idx_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_rsv_issue_sched.sv
// Self-checking bench for rsv_issue_sched: directed scenarios with a scoreboard queue of
// expected issue indices, popped whenever the execution-unit handshake fires.
module tb_rsv_issue_sched;

  logic clk;
  logic rst;

  rsv_issue_sched_if #(.IDX_W(2), .TAG_W(5)) bus ();

  rsv_issue_sched #(.ENTRIES(4), .IDX_W(2), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] t1, input logic r1,
                               input logic [4:0] t2, input logic r2);
    bus.alloc_valid  = av;
    bus.alloc_s1_tag = t1;
    bus.alloc_s1_rdy = r1;
    bus.alloc_s2_tag = t2;
    bus.alloc_s2_rdy = r2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.wb_valid    = 1'b0;
    bus.wb_tag      = '0;
    bus.issue_ready = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic alloc_one(input string tag, input int exp_idx, input logic [4:0] t1,
                           input logic r1, input logic [4:0] t2, input logic r2);
    applyStimulus(1'b1, t1, r1, t2, r2);
    settle();
    checkOutput({tag, "_ready"}, bus.alloc_ready, 1);
    checkOutput({tag, "_idx"}, bus.alloc_idx, exp_idx);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wait_level(input string tag, input int lvl, input int budget);
    int n = 0;
    while (exp_q.size() > lvl && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, exp_q.size(), lvl);
  endtask

  // Handshake sampled mid-cycle; a fire occurs at the following rising edge.
  always @(negedge clk) begin
    if (!rst && !bus.flush && bus.issue_valid && bus.issue_ready) begin
      fires++;
      checkOutput("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        checkOutput("issue_order", bus.issue_idx, exp_q.pop_front());
      end
    end
  end

  initial begin
    int fires_before;
    idle();
    rst = 1'b1;
    tick();
    tick();
    settle();
    checkOutput("rst_alloc_ready", bus.alloc_ready, 0);
    checkOutput("rst_issue_valid", bus.issue_valid, 0);
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_alloc_idx", bus.alloc_idx, 0);
    rst = 1'b0;
    settle();
    checkOutput("post_rst_alloc_ready", bus.alloc_ready, 1);

    $display("[TB] single ready instruction");
    alloc_one("t1_alloc", 0, 5'd1, 1'b1, 5'd2, 1'b1);
    exp_q.push_back(0);
    checkOutput("t1_valid_early", bus.issue_valid, 0);
    checkOutput("t1_count", bus.count, 1);
    tick();
    checkOutput("t1_valid", bus.issue_valid, 1);
    checkOutput("t1_idx", bus.issue_idx, 0);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t1_count_after", bus.count, 0);
    checkOutput("t1_valid_after", bus.issue_valid, 0);

    $display("[TB] fill station, slot 0 waits on tag 7");
    alloc_one("t2_a0", 0, 5'd7, 1'b0, 5'd3, 1'b1);
    alloc_one("t2_a1", 1, 5'd4, 1'b1, 5'd5, 1'b1);
    alloc_one("t2_a2", 2, 5'd6, 1'b1, 5'd8, 1'b1);
    alloc_one("t2_a3", 3, 5'd9, 1'b1, 5'd10, 1'b1);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    checkOutput("t2_full_ready", bus.alloc_ready, 0);
    checkOutput("t2_full_count", bus.count, 4);
    checkOutput("t2_full_idx", bus.alloc_idx, 0);
    bus.issue_ready = 1'b1;
    wait_level("t2_drain3", 1, 20);
    tick();
    checkOutput("t2_waiting_valid", bus.issue_valid, 0);
    checkOutput("t2_waiting_count", bus.count, 1);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 5'd8;
    tick();
    bus.wb_valid = 1'b0;
    tick();
    checkOutput("t2_wrong_tag_valid", bus.issue_valid, 0);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 5'd7;
    tick();
    bus.wb_valid = 1'b0;
    checkOutput("t2_wake_valid_early", bus.issue_valid, 0);
    tick();
    checkOutput("t2_wake_valid", bus.issue_valid, 1);
    checkOutput("t2_wake_idx", bus.issue_idx, 0);
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t2_final_count", bus.count, 0);
    checkOutput("t2_sb_empty", exp_q.size(), 0);

    $display("[TB] same-cycle bypass");
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 5'd12;
    alloc_one("t3_alloc", 0, 5'd1, 1'b1, 5'd12, 1'b0);
    bus.wb_valid = 1'b0;
    exp_q.push_back(0);
    checkOutput("t3_valid_early", bus.issue_valid, 0);
    tick();
    checkOutput("t3_valid", bus.issue_valid, 1);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t3_count", bus.count, 0);

    $display("[TB] backpressure");
    alloc_one("t4_a0", 0, 5'd1, 1'b1, 5'd2, 1'b1);
    alloc_one("t4_a1", 1, 5'd3, 1'b1, 5'd4, 1'b1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", bus.issue_valid, 1);
      checkOutput("t4_hold_idx", bus.issue_idx, 0);
      tick();
    end
    checkOutput("t4_hold_count", bus.count, 2);
    bus.issue_ready = 1'b1;
    tick();
    checkOutput("t4_b2b_valid", bus.issue_valid, 1);
    checkOutput("t4_b2b_idx", bus.issue_idx, 1);
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t4_count", bus.count, 0);
    checkOutput("t4_valid_after", bus.issue_valid, 0);

    $display("[TB] full with simultaneous issue and alloc");
    alloc_one("t5_a0", 0, 5'd1, 1'b1, 5'd2, 1'b1);
    alloc_one("t5_a1", 1, 5'd1, 1'b1, 5'd2, 1'b1);
    alloc_one("t5_a2", 2, 5'd1, 1'b1, 5'd2, 1'b1);
    alloc_one("t5_a3", 3, 5'd1, 1'b1, 5'd2, 1'b1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    checkOutput("t5_full_count", bus.count, 4);
    bus.issue_ready = 1'b1;
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    settle();
    checkOutput("t5_full_ready", bus.alloc_ready, 0);
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t5_count3", bus.count, 3);
    checkOutput("t5_ready_again", bus.alloc_ready, 1);
    checkOutput("t5_reuse_idx", bus.alloc_idx, 0);
    tick();
    exp_q.push_back(0);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    checkOutput("t5_count4", bus.count, 4);
    bus.issue_ready = 1'b1;
    wait_level("t5_drain", 0, 20);
    tick();
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t5_count0", bus.count, 0);

    $display("[TB] flush during issue handshake");
    alloc_one("t6_a0", 0, 5'd1, 1'b1, 5'd2, 1'b1);
    alloc_one("t6_a1", 1, 5'd1, 1'b1, 5'd2, 1'b1);
    checkOutput("t6_valid", bus.issue_valid, 1);
    fires_before    = fires;
    bus.issue_ready = 1'b1;
    bus.flush       = 1'b1;
    settle();
    checkOutput("t6_ready_in_flush", bus.alloc_ready, 0);
    tick();
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b0;
    settle();
    checkOutput("t6_valid_after", bus.issue_valid, 0);
    checkOutput("t6_count_after", bus.count, 0);
    checkOutput("t6_alloc_ready", bus.alloc_ready, 1);
    tick();
    checkOutput("t6_still_empty", bus.issue_valid, 0);
    checkOutput("t6_no_fire", fires, fires_before);

    $display("[TB] reset mid-operation");
    alloc_one("t7_a0", 0, 5'd3, 1'b0, 5'd2, 1'b1);
    alloc_one("t7_a1", 1, 5'd1, 1'b1, 5'd2, 1'b1);
    tick();
    checkOutput("t7_idx_pre", bus.issue_idx, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checkOutput("t7_valid", bus.issue_valid, 0);
    checkOutput("t7_idx", bus.issue_idx, 0);
    checkOutput("t7_count", bus.count, 0);

    checkOutput("sb_final_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
